// File: rtl/instr_load_ctrl.sv
// Streams a program into instruction memory and holds the core in reset until it is complete.
// Optional IMEM_LOAD_CHECKSUM_EN adds a running checksum that gates the release of the core.
module instr_load_ctrl #(
   parameter  int WIDTH   = 32,
   parameter  int SIZE    = 256,
   localparam int LOGSIZE = $clog2(SIZE)
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic [LOGSIZE:0]   i_word_count,
   input  logic               i_s_valid,
   input  logic [WIDTH-1:0]   i_s_data,
`ifdef IMEM_LOAD_CHECKSUM_EN
   input  logic [WIDTH-1:0]   i_expected_sum,
   output logic [WIDTH-1:0]   o_checksum,
   output logic               o_chk_err,
`endif
   output logic               o_s_ready,
   output logic [WIDTH-1:0]   o_instr_in,
   output logic [LOGSIZE+1:0] o_wr_addr,
   output logic               o_wr_en,
   output logic               o_core_reset,
   output logic               o_busy,
   output logic               o_done
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] RUN   = 2'd3;

   localparam logic [LOGSIZE:0] SIZE_W = (LOGSIZE+1)'(SIZE);

   logic [1:0]         r_state;
   logic [LOGSIZE:0]   r_count;
   logic [LOGSIZE:0]   r_index;
   logic               r_wr_en;
   logic [WIDTH-1:0]   r_instr_in;
   logic [LOGSIZE+1:0] r_wr_addr;
   logic               r_done;
`ifdef IMEM_LOAD_CHECKSUM_EN
   logic [WIDTH-1:0]   r_checksum;
   logic               r_chk_err;
`endif

   logic               w_start_ok;
   logic [LOGSIZE:0]   w_count_clamped;
   logic               w_last;

   assign w_start_ok      = i_start && ((r_state == IDLE) || (r_state == RUN));
   assign w_count_clamped = (i_word_count > SIZE_W) ? SIZE_W : i_word_count;
   assign w_last          = (r_index == (r_count - 1'b1));

   // Writes are issued one cycle after each stream transfer; DRAIN covers the final one.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= IDLE;
         r_count    <= '0;
         r_index    <= '0;
         r_wr_en    <= 1'b0;
         r_instr_in <= '0;
         r_wr_addr  <= '0;
         r_done     <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
         r_checksum <= '0;
         r_chk_err  <= 1'b0;
`endif
      end else begin
         r_wr_en <= 1'b0;
         r_done  <= 1'b0;
         case (r_state)
            IDLE, RUN: begin
               if (w_start_ok) begin
                  r_count <= w_count_clamped;
                  r_index <= '0;
                  r_state <= (w_count_clamped == '0) ? DRAIN : LOAD;
`ifdef IMEM_LOAD_CHECKSUM_EN
                  r_checksum <= '0;
                  r_chk_err  <= 1'b0;
`endif
               end
            end
            LOAD: begin
               if (i_s_valid) begin
                  r_wr_en    <= 1'b1;
                  r_instr_in <= i_s_data;
                  r_wr_addr  <= {r_index[LOGSIZE-1:0], 2'b00};
                  r_index    <= r_index + 1'b1;
`ifdef IMEM_LOAD_CHECKSUM_EN
                  r_checksum <= r_checksum + i_s_data;
`endif
                  if (w_last) begin
                     r_state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
`ifdef IMEM_LOAD_CHECKSUM_EN
               // A corrupt image leaves the core held in reset until the next start.
               if (r_checksum != i_expected_sum) begin
                  r_state   <= IDLE;
                  r_chk_err <= 1'b1;
               end else begin
                  r_state <= RUN;
                  r_done  <= 1'b1;
               end
`else
               r_state <= RUN;
               r_done  <= 1'b1;
`endif
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_s_ready    = (r_state == LOAD);
   assign o_busy       = (r_state == LOAD) || (r_state == DRAIN);
   assign o_core_reset = (r_state != RUN);
   assign o_wr_en      = r_wr_en;
   assign o_instr_in   = r_instr_in;
   assign o_wr_addr    = r_wr_addr;
   assign o_done       = r_done;
`ifdef IMEM_LOAD_CHECKSUM_EN
   assign o_checksum   = r_checksum;
   assign o_chk_err    = r_chk_err;
`endif

endmodule

// File: tb/tb_instr_load_ctrl.sv
// Directed self-checking bench for instr_load_ctrl (SIZE reduced to 8 so clamping is cheap to exercise).
// Define IMEM_LOAD_CHECKSUM_EN on both RTL and bench to cover the checksum option.
module tb_instr_load_ctrl;

   localparam int WIDTH   = 32;
   localparam int SIZE    = 8;
   localparam int LOGSIZE = 3;

   logic               clock;
   logic               rstN;
   logic               start;
   logic [LOGSIZE:0]   wordCount;
   logic               sValid;
   logic [WIDTH-1:0]   sData;
   logic               sReady;
   logic [WIDTH-1:0]   instrIn;
   logic [LOGSIZE+1:0] wrAddr;
   logic               wrEn;
   logic               coreReset;
   logic               busy;
   logic               done;
`ifdef IMEM_LOAD_CHECKSUM_EN
   logic [WIDTH-1:0]   expectedSum;
   logic [WIDTH-1:0]   checksum;
   logic               chkErr;
`endif

   int checkCount = 0;
   int errorCount = 0;
   int writeCount = 0;
   int lastAddr   = 0;
   int baseCount;
   int nWrites;
   logic vPat [5];

   instr_load_ctrl #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
      .i_clk        (clock),
      .i_rst_n      (rstN),
      .i_start      (start),
      .i_word_count (wordCount),
      .i_s_valid    (sValid),
      .i_s_data     (sData),
`ifdef IMEM_LOAD_CHECKSUM_EN
      .i_expected_sum (expectedSum),
      .o_checksum     (checksum),
      .o_chk_err      (chkErr),
`endif
      .o_s_ready    (sReady),
      .o_instr_in   (instrIn),
      .o_wr_addr    (wrAddr),
      .o_wr_en      (wrEn),
      .o_core_reset (coreReset),
      .o_busy       (busy),
      .o_done       (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Counts memory writes independently of the directed checks.
   always @(negedge clock) begin
      if (wrEn) begin
         writeCount = writeCount + 1;
         lastAddr   = int'(wrAddr);
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount = checkCount + 1;
      if (observed !== expected) begin
         errorCount = errorCount + 1;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus();
      @(posedge clock);
      #1;
   endtask

   initial begin
      rstN = 1'b0; start = 1'b0; wordCount = '0; sValid = 1'b0; sData = '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      expectedSum = '0;
`endif
      #3;
      checkOutput("rst_wr_en", 64'(wrEn), 64'd0);
      checkOutput("rst_instr_in", 64'(instrIn), 64'd0);
      checkOutput("rst_wr_addr", 64'(wrAddr), 64'd0);
      checkOutput("rst_s_ready", 64'(sReady), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      checkOutput("rst_core_reset", 64'(coreReset), 64'd1);
      applyStimulus();
      applyStimulus();
      rstN = 1'b1;
      applyStimulus();
      checkOutput("idle_core_reset", 64'(coreReset), 64'd1);
      checkOutput("idle_s_ready", 64'(sReady), 64'd0);

      // Four words back to back
      start = 1'b1; wordCount = 4'd4; sValid = 1'b1; sData = 32'h11;
      applyStimulus();
      start = 1'b0;
      checkOutput("load_s_ready", 64'(sReady), 64'd1);
      checkOutput("load_busy", 64'(busy), 64'd1);
      checkOutput("load_core_reset", 64'(coreReset), 64'd1);
      checkOutput("load_no_wr", 64'(wrEn), 64'd0);
      for (int i = 0; i < 4; i++) begin
         sData = WIDTH'(32'h11 * (i + 1));
         applyStimulus();
         checkOutput("b2b_wr_en", 64'(wrEn), 64'd1);
         checkOutput("b2b_addr", 64'(wrAddr), 64'(4 * i));
         checkOutput("b2b_data", 64'(instrIn), 64'(32'h11 * (i + 1)));
      end
      checkOutput("drain_s_ready", 64'(sReady), 64'd0);
      checkOutput("drain_busy", 64'(busy), 64'd1);
      checkOutput("drain_done", 64'(done), 64'd0);
      sValid = 1'b0;
      applyStimulus();
      checkOutput("run_done", 64'(done), 64'd1);
      checkOutput("run_core_reset", 64'(coreReset), 64'd0);
      checkOutput("run_wr_en", 64'(wrEn), 64'd0);
      checkOutput("run_busy", 64'(busy), 64'd0);
      applyStimulus();
      checkOutput("done_pulse_end", 64'(done), 64'd0);

      // Stalled stream with gaps
      vPat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      baseCount = writeCount;
      start = 1'b1; wordCount = 4'd3; sValid = 1'b0;
      applyStimulus();
      start = 1'b0;
      checkOutput("gap_core_reset", 64'(coreReset), 64'd1);
      nWrites = 0;
      for (int k = 0; k < 5; k++) begin
         sValid = vPat[k];
         sData = WIDTH'(32'hA0 + k);
         applyStimulus();
         checkOutput("gap_wr_en", 64'(wrEn), 64'(vPat[k]));
         if (vPat[k]) begin
            checkOutput("gap_addr", 64'(wrAddr), 64'(4 * nWrites));
            checkOutput("gap_data", 64'(instrIn), 64'(32'hA0 + k));
            nWrites++;
         end
      end
      sValid = 1'b0;
      checkOutput("gap_drain_ready", 64'(sReady), 64'd0);
      applyStimulus();
      checkOutput("gap_done", 64'(done), 64'd1);
      checkOutput("gap_write_total", 64'(writeCount - baseCount), 64'd3);

      // Reload from RUN, start pulses during LOAD/DRAIN ignored
      start = 1'b1; wordCount = 4'd2; sValid = 1'b0;
      applyStimulus();
      checkOutput("reload_core_reset", 64'(coreReset), 64'd1);
      wordCount = 4'd7;
      applyStimulus();
      applyStimulus();
      checkOutput("reload_stall_wr", 64'(wrEn), 64'd0);
      checkOutput("reload_stall_ready", 64'(sReady), 64'd1);
      sValid = 1'b1; sData = 32'h55;
      applyStimulus();
      checkOutput("reload_addr0", 64'(wrAddr), 64'd0);
      checkOutput("reload_data0", 64'(instrIn), 64'h55);
      sData = 32'h66;
      applyStimulus();
      checkOutput("reload_addr1", 64'(wrAddr), 64'd4);
      checkOutput("reload_data1", 64'(instrIn), 64'h66);
      checkOutput("reload_drain", 64'(sReady), 64'd0);
      sValid = 1'b0;
      applyStimulus();
      start = 1'b0;
      checkOutput("reload_done", 64'(done), 64'd1);
      checkOutput("reload_run", 64'(coreReset), 64'd0);
      applyStimulus();
      checkOutput("reload_stay_run", 64'(coreReset), 64'd0);

      // Asynchronous reset mid-load
      start = 1'b1; wordCount = 4'd8; sValid = 1'b1; sData = 32'h100;
      applyStimulus();
      start = 1'b0;
      applyStimulus();
      sData = 32'h101;
      applyStimulus();
      checkOutput("mid_wr_pending", 64'(wrEn), 64'd1);
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("async_wr_en", 64'(wrEn), 64'd0);
      checkOutput("async_core_reset", 64'(coreReset), 64'd1);
      checkOutput("async_s_ready", 64'(sReady), 64'd0);
      checkOutput("async_busy", 64'(busy), 64'd0);
      applyStimulus();
      rstN = 1'b1;
      applyStimulus();
      checkOutput("post_rst_idle", 64'(sReady), 64'd0);
      start = 1'b1; wordCount = 4'd1; sData = 32'h77;
      applyStimulus();
      start = 1'b0;
      applyStimulus();
      checkOutput("post_rst_wr", 64'(wrEn), 64'd1);
      checkOutput("post_rst_addr", 64'(wrAddr), 64'd0);
      checkOutput("post_rst_data", 64'(instrIn), 64'h77);
      sValid = 1'b0;
      applyStimulus();
      checkOutput("post_rst_done", 64'(done), 64'd1);

      // Zero-length load
      baseCount = writeCount;
      sValid = 1'b1; start = 1'b1; wordCount = 4'd0;
      applyStimulus();
      start = 1'b0;
      checkOutput("zero_busy", 64'(busy), 64'd1);
      checkOutput("zero_s_ready", 64'(sReady), 64'd0);
      checkOutput("zero_done_early", 64'(done), 64'd0);
      applyStimulus();
      checkOutput("zero_done", 64'(done), 64'd1);
      checkOutput("zero_writes", 64'(writeCount - baseCount), 64'd0);

      // Oversized count clamps to SIZE
      baseCount = writeCount;
      start = 1'b1; wordCount = 4'(SIZE + 5); sValid = 1'b1;
      applyStimulus();
      start = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (!sReady) break;
         sData = WIDTH'(i);
         applyStimulus();
      end
      checkOutput("clamp_left_load", 64'(sReady), 64'd0);
      sValid = 1'b0;
      applyStimulus();
      checkOutput("clamp_done", 64'(done), 64'd1);
      checkOutput("clamp_writes", 64'(writeCount - baseCount), 64'(SIZE));
      checkOutput("clamp_last_addr", 64'(lastAddr), 64'(4 * (SIZE - 1)));

`ifdef IMEM_LOAD_CHECKSUM_EN
      // Checksum match then mismatch
      expectedSum = 32'd6;
      start = 1'b1; wordCount = 4'd3; sValid = 1'b1; sData = 32'd1;
      applyStimulus();
      start = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         sData = WIDTH'(i);
         applyStimulus();
      end
      sValid = 1'b0;
      applyStimulus();
      checkOutput("sum_ok_done", 64'(done), 64'd1);
      checkOutput("sum_ok_run", 64'(coreReset), 64'd0);
      checkOutput("sum_ok_err", 64'(chkErr), 64'd0);
      checkOutput("sum_value", 64'(checksum), 64'd6);
      expectedSum = 32'd7;
      start = 1'b1; sValid = 1'b1;
      applyStimulus();
      start = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         sData = WIDTH'(i);
         applyStimulus();
      end
      sValid = 1'b0;
      applyStimulus();
      checkOutput("sum_bad_done", 64'(done), 64'd0);
      checkOutput("sum_bad_core_reset", 64'(coreReset), 64'd1);
      checkOutput("sum_bad_err", 64'(chkErr), 64'd1);
      checkOutput("sum_bad_idle", 64'(busy), 64'd0);
      applyStimulus();
      checkOutput("sum_bad_err_hold", 64'(chkErr), 64'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
